// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and helpers for the hazard/stall unit: pipeline slot bus, stall bus, FSM states.
package hazard_stall_unit_pkg;

    localparam int REG_AW      = 5;
    localparam int MEM_OP_BITS = 4;

    // Loads carry a 1 in the op MSB; stores carry 01 in the top two bits.
    localparam logic       LOAD_PRFX  = 1'b1;
    localparam logic [1:0] STORE_PRFX = 2'b01;

    localparam logic [MEM_OP_BITS-1:0] MEM_NONE = 4'b0000;
    localparam logic [MEM_OP_BITS-1:0] MEM_LW   = 4'b1010;
    localparam logic [MEM_OP_BITS-1:0] MEM_SW   = 4'b0110;

    typedef struct packed {
        logic [REG_AW-1:0]      rs1;
        logic [REG_AW-1:0]      rs2;
        logic [REG_AW-1:0]      rd;
        logic                   rf_wr_en;
        logic [MEM_OP_BITS-1:0] mem_op;
    } pipeline_bus_t;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_bubble;
        logic idex_stall;
        logic exmem_stall;
        logic ifid_flush;
    } stall_bus_t;

    typedef enum logic [1:0] {
        HZ_IDLE,
        HZ_LU_STALL,
        HZ_MEM_WAIT
    } hz_state_t;

    function automatic logic is_load(input logic [MEM_OP_BITS-1:0] op);
        return op[MEM_OP_BITS-1] == LOAD_PRFX;
    endfunction

    function automatic logic is_store(input logic [MEM_OP_BITS-1:0] op);
        return op[MEM_OP_BITS-1 -: 2] == STORE_PRFX;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX/MEM slot view into the hazard unit and its stall/counter results.
interface hazard_stall_unit_if
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 32
);
    pipeline_bus_t    id_bus_i;
    pipeline_bus_t    ex_bus_i;
    pipeline_bus_t    mem_bus_i;
    logic             id_valid_i;
    logic             ex_valid_i;
    logic             mem_valid_i;
    logic             dmem_ready_i;
    logic             br_flush_i;
    stall_bus_t       stall_o;
    logic [CNT_W-1:0] lu_stall_cnt_o;
    logic [CNT_W-1:0] mem_stall_cnt_o;
    logic             mem_timeout_o;

    modport master (
        output id_bus_i, ex_bus_i, mem_bus_i, id_valid_i, ex_valid_i, mem_valid_i,
               dmem_ready_i, br_flush_i,
        input  stall_o, lu_stall_cnt_o, mem_stall_cnt_o, mem_timeout_o
    );

    modport slave (
        input  id_bus_i, ex_bus_i, mem_bus_i, id_valid_i, ex_valid_i, mem_valid_i,
               dmem_ready_i, br_flush_i,
        output stall_o, lu_stall_cnt_o, mem_stall_cnt_o, mem_timeout_o
    );
endinterface

// File: rtl/hazard_stall_unit_perf_counter.sv
// Free-running wrapping event counter with enable.
module hz_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall unit: load-use stalls, dmem-wait freeze, taken-branch flush,
// plus stall performance counters and a sticky dmem timeout flag.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 64,
    parameter int CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave hz
);
    localparam int                LU_W     = 3;
    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [LU_W-1:0]   LU_INIT  = LU_W'(LU_STALL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         r_state, w_state_nxt;
    logic [LU_W-1:0]   r_lu_cnt, w_lu_cnt_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic              w_lu, w_mw, w_mem_hold, w_lu_hold;
    logic              w_lu_stall_en, w_mem_stall_en;
    stall_bus_t        w_stall;
    logic [CNT_W-1:0]  w_lu_stall_cnt, w_mem_stall_cnt;
    logic              w_unused;

    assign w_lu = hz.ex_valid_i && hz.id_valid_i
               && is_load(hz.ex_bus_i.mem_op) && hz.ex_bus_i.rf_wr_en
               && (hz.ex_bus_i.rd != '0)
               && (hz.ex_bus_i.rd == hz.id_bus_i.rs1 || hz.ex_bus_i.rd == hz.id_bus_i.rs2);

    assign w_mw = hz.mem_valid_i && !hz.dmem_ready_i
               && (is_load(hz.mem_bus_i.mem_op) || is_store(hz.mem_bus_i.mem_op));

    // The cycle ready is seen completes the access, so the freeze drops in that same cycle.
    assign w_mem_hold = w_mw || (r_state == HZ_MEM_WAIT && !hz.dmem_ready_i);
    assign w_lu_hold  = w_lu || (r_state == HZ_LU_STALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HZ_IDLE;
            r_lu_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lu_cnt_nxt = r_lu_cnt;
        case (r_state)
            HZ_IDLE: begin
                if (w_mw) begin
                    w_state_nxt = HZ_MEM_WAIT;
                end else if (!hz.br_flush_i && w_lu && LU_STALL_CYCLES > 1) begin
                    w_state_nxt  = HZ_LU_STALL;
                    w_lu_cnt_nxt = LU_INIT;
                end
            end
            HZ_LU_STALL: begin
                // Remaining lu_cnt is preserved across a memory wait and resumed after it.
                if (w_mw) begin
                    w_state_nxt = HZ_MEM_WAIT;
                end else if (hz.br_flush_i || r_lu_cnt <= LU_W'(1)) begin
                    w_state_nxt  = HZ_IDLE;
                    w_lu_cnt_nxt = '0;
                end else begin
                    w_lu_cnt_nxt = r_lu_cnt - LU_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (hz.dmem_ready_i) w_state_nxt = (r_lu_cnt != '0) ? HZ_LU_STALL : HZ_IDLE;
            end
            default: begin
                w_state_nxt  = HZ_IDLE;
                w_lu_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_stall        = '0;
        w_mem_stall_en = 1'b0;
        w_lu_stall_en  = 1'b0;
        if (!rst) begin
            if (w_mem_hold) begin
                // A branch in EX is held too and re-asserts once memory frees up.
                w_stall.pc_stall    = 1'b1;
                w_stall.ifid_stall  = 1'b1;
                w_stall.idex_stall  = 1'b1;
                w_stall.exmem_stall = 1'b1;
                w_mem_stall_en      = 1'b1;
            end else if (hz.br_flush_i) begin
                w_stall.ifid_flush  = 1'b1;
                w_stall.idex_bubble = 1'b1;
            end else if (w_lu_hold) begin
                w_stall.pc_stall    = 1'b1;
                w_stall.ifid_stall  = 1'b1;
                w_stall.idex_bubble = 1'b1;
                w_lu_stall_en       = 1'b1;
            end
        end
    end

    // Wait length counts every frozen cycle, including the one that enters MEM_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (!w_mem_hold)                r_wait_cnt <= '0;
            else if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (w_mem_hold && r_wait_cnt == WAIT_MAX - WAIT_W'(1)) r_timeout <= 1'b1;
        end
    end

    hz_perf_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_lu_stall_en),
        .o_cnt (w_lu_stall_cnt)
    );

    hz_perf_counter #(.CNT_W(CNT_W)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_mem_stall_en),
        .o_cnt (w_mem_stall_cnt)
    );

    assign hz.stall_o         = w_stall;
    assign hz.lu_stall_cnt_o  = w_lu_stall_cnt;
    assign hz.mem_stall_cnt_o = w_mem_stall_cnt;
    assign hz.mem_timeout_o   = r_timeout;

    assign w_unused = ^{hz.id_bus_i.rd, hz.id_bus_i.rf_wr_en, hz.id_bus_i.mem_op,
                        hz.ex_bus_i.rs1, hz.ex_bus_i.rs2,
                        hz.mem_bus_i.rs1, hz.mem_bus_i.rs2, hz.mem_bus_i.rd,
                        hz.mem_bus_i.rf_wr_en};
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: u_a (1 load-use bubble, timeout 4) and u_b (3 bubbles, timeout 64).
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LU   = 6'b111000;
    localparam logic [5:0] S_FL   = 6'b001001;
    localparam logic [5:0] S_MEM  = 6'b110110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(32)) if_a ();
    hazard_stall_unit_if #(.CNT_W(32)) if_b ();

    hazard_stall_unit #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(32)) u_a (
        .clk (clk), .rst (rst), .hz (if_a)
    );
    hazard_stall_unit #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(32)) u_b (
        .clk (clk), .rst (rst), .hz (if_b)
    );

    function automatic pipeline_bus_t bus(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic wr,
                                          input logic [3:0] op);
        pipeline_bus_t b;
        b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.rf_wr_en = wr; b.mem_op = op;
        return b;
    endfunction

    task automatic set_a(input pipeline_bus_t id, input pipeline_bus_t ex, input pipeline_bus_t mem,
                         input logic idv, input logic exv, input logic memv,
                         input logic rdy, input logic br);
        if_a.id_bus_i = id; if_a.ex_bus_i = ex; if_a.mem_bus_i = mem;
        if_a.id_valid_i = idv; if_a.ex_valid_i = exv; if_a.mem_valid_i = memv;
        if_a.dmem_ready_i = rdy; if_a.br_flush_i = br;
    endtask

    task automatic set_b(input pipeline_bus_t id, input pipeline_bus_t ex, input pipeline_bus_t mem,
                         input logic idv, input logic exv, input logic memv,
                         input logic rdy, input logic br);
        if_b.id_bus_i = id; if_b.ex_bus_i = ex; if_b.mem_bus_i = mem;
        if_b.id_valid_i = idv; if_b.ex_valid_i = exv; if_b.mem_valid_i = memv;
        if_b.dmem_ready_i = rdy; if_b.br_flush_i = br;
    endtask

    task automatic idle_all();
        set_a(bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), 0,0,0,1,0);
        set_b(bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), 0,0,0,1,0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_all();
        set_a(bus(5,1,0,0,MEM_NONE), bus(0,0,5,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,0);
        #7;
        n_cmp++; if (if_a.stall_o !== S_NONE) begin n_err++; $display("FAIL reset_forces_stall_zero: got %b want %b", if_a.stall_o, S_NONE); end
        n_cmp++; if (if_a.lu_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_lu_cnt: got %0d want 0", if_a.lu_stall_cnt_o); end
        n_cmp++; if (if_a.mem_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_mem_cnt: got %0d want 0", if_a.mem_stall_cnt_o); end
        n_cmp++; if (if_a.mem_timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", if_a.mem_timeout_o); end
        n_cmp++; if (u_b.r_state !== HZ_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", u_b.r_state, HZ_IDLE); end
        @(negedge clk);
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_load_use();
        step(); set_a(bus(5,1,0,0,MEM_NONE), bus(0,0,5,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,0); #3;
        n_cmp++; if (if_a.stall_o !== S_LU) begin n_err++; $display("FAIL lu_rs1_stall: got %b want %b", if_a.stall_o, S_LU); end
        // Load advanced to MEM, bubble in EX, consumer still in ID.
        step(); set_a(bus(5,1,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,5,1,MEM_LW), 1,0,1,1,0); #3;
        n_cmp++; if (if_a.stall_o !== S_NONE) begin n_err++; $display("FAIL lu_single_bubble: got %b want %b", if_a.stall_o, S_NONE); end
        n_cmp++; if (if_a.lu_stall_cnt_o !== 32'd1) begin n_err++; $display("FAIL lu_cnt_one: got %0d want 1", if_a.lu_stall_cnt_o); end
        step(); set_a(bus(3,7,0,0,MEM_NONE), bus(0,0,7,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,0); #3;
        n_cmp++; if (if_a.stall_o !== S_LU) begin n_err++; $display("FAIL lu_rs2_stall: got %b want %b", if_a.stall_o, S_LU); end
        step(); idle_all(); #3;
        n_cmp++; if (if_a.stall_o !== S_NONE) begin n_err++; $display("FAIL lu_rs2_release: got %b want %b", if_a.stall_o, S_NONE); end
        n_cmp++; if (if_a.lu_stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL lu_cnt_two: got %0d want 2", if_a.lu_stall_cnt_o); end
    endtask

    task automatic test_no_hazard();
        pipeline_bus_t id_v [5];
        pipeline_bus_t ex_v [5];
        logic          idv_v [5];
        logic          exv_v [5];
        id_v[0] = bus(0,0,0,0,MEM_NONE); ex_v[0] = bus(0,0,0,1,MEM_LW);   idv_v[0] = 1; exv_v[0] = 1; // lw x0
        id_v[1] = bus(5,2,0,0,MEM_NONE); ex_v[1] = bus(0,0,5,1,MEM_NONE); idv_v[1] = 1; exv_v[1] = 1; // add x5
        id_v[2] = bus(5,2,0,0,MEM_NONE); ex_v[2] = bus(0,0,5,1,MEM_LW);   idv_v[2] = 0; exv_v[2] = 1; // ID invalid
        id_v[3] = bus(5,2,0,0,MEM_NONE); ex_v[3] = bus(0,0,5,1,MEM_LW);   idv_v[3] = 1; exv_v[3] = 0; // EX invalid
        id_v[4] = bus(5,2,0,0,MEM_NONE); ex_v[4] = bus(0,0,5,0,MEM_LW);   idv_v[4] = 1; exv_v[4] = 1; // no rf write
        for (int i = 0; i < 5; i++) begin
            step(); set_a(id_v[i], ex_v[i], bus(0,0,0,0,MEM_NONE), idv_v[i], exv_v[i], 0, 1, 0); #3;
            n_cmp++; if (if_a.stall_o !== S_NONE) begin n_err++; $display("FAIL no_hazard_%0d: got %b want %b", i, if_a.stall_o, S_NONE); end
        end
        step(); idle_all(); #3;
        n_cmp++; if (if_a.lu_stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL no_hazard_lu_cnt: got %0d want 2", if_a.lu_stall_cnt_o); end
    endtask

    task automatic test_flush_wins();
        step();
        set_a(bus(5,1,0,0,MEM_NONE), bus(0,0,5,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,1);
        set_b(bus(5,1,0,0,MEM_NONE), bus(0,0,5,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,1);
        #3;
        n_cmp++; if (if_a.stall_o !== S_FL) begin n_err++; $display("FAIL flush_wins_a: got %b want %b", if_a.stall_o, S_FL); end
        n_cmp++; if (if_b.stall_o !== S_FL) begin n_err++; $display("FAIL flush_wins_b: got %b want %b", if_b.stall_o, S_FL); end
        step(); idle_all(); #3;
        n_cmp++; if (u_b.r_state !== HZ_IDLE) begin n_err++; $display("FAIL flush_state_idle: got %0d want %0d", u_b.r_state, HZ_IDLE); end
        n_cmp++; if (if_b.stall_o !== S_NONE) begin n_err++; $display("FAIL flush_no_lu_after: got %b want %b", if_b.stall_o, S_NONE); end
        n_cmp++; if (if_b.lu_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL flush_lu_cnt: got %0d want 0", if_b.lu_stall_cnt_o); end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 3; c++) begin
            step();
            set_a(bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_SW), 0,0,1,0, c == 1);
            #3;
            n_cmp++; if (if_a.stall_o !== S_MEM) begin n_err++; $display("FAIL mem_wait_cyc%0d: got %b want %b", c, if_a.stall_o, S_MEM); end
        end
        n_cmp++; if (if_a.mem_timeout_o !== 1'b0) begin n_err++; $display("FAIL mem_wait_no_timeout: got %b want 0", if_a.mem_timeout_o); end
        step(); set_a(bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_SW), 0,0,1,1,0); #3;
        n_cmp++; if (if_a.stall_o !== S_NONE) begin n_err++; $display("FAIL mem_wait_release: got %b want %b", if_a.stall_o, S_NONE); end
        step(); idle_all(); #3;
        n_cmp++; if (if_a.mem_stall_cnt_o !== 32'd3) begin n_err++; $display("FAIL mem_stall_cnt3: got %0d want 3", if_a.mem_stall_cnt_o); end
    endtask

    task automatic test_timeout();
        for (int c = 1; c <= 6; c++) begin
            step(); set_a(bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_LW), 0,0,1,0,0); #3;
            n_cmp++; if (if_a.stall_o !== S_MEM) begin n_err++; $display("FAIL timeout_stall_cyc%0d: got %b want %b", c, if_a.stall_o, S_MEM); end
            if (c == 4) begin
                n_cmp++; if (if_a.mem_timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b want 0", if_a.mem_timeout_o); end
            end
            if (c == 5) begin
                n_cmp++; if (if_a.mem_timeout_o !== 1'b1) begin n_err++; $display("FAIL timeout_rise: got %b want 1", if_a.mem_timeout_o); end
            end
        end
        step(); set_a(bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_LW), 0,0,1,1,0); #3;
        n_cmp++; if (if_a.stall_o !== S_NONE) begin n_err++; $display("FAIL timeout_release: got %b want %b", if_a.stall_o, S_NONE); end
        step(); idle_all(); #3;
        n_cmp++; if (if_a.mem_timeout_o !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b want 1", if_a.mem_timeout_o); end
        n_cmp++; if (if_a.mem_stall_cnt_o !== 32'd9) begin n_err++; $display("FAIL timeout_mem_cnt9: got %0d want 9", if_a.mem_stall_cnt_o); end
    endtask

    task automatic test_lu_multi();
        step(); set_b(bus(9,1,0,0,MEM_NONE), bus(0,0,9,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,0); #3;
        n_cmp++; if (if_b.stall_o !== S_LU) begin n_err++; $display("FAIL lu3_cyc1: got %b want %b", if_b.stall_o, S_LU); end
        step(); set_b(bus(9,1,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,9,1,MEM_LW), 1,0,1,1,0); #3;
        n_cmp++; if (if_b.stall_o !== S_LU) begin n_err++; $display("FAIL lu3_cyc2: got %b want %b", if_b.stall_o, S_LU); end
        n_cmp++; if (u_b.r_state !== HZ_LU_STALL) begin n_err++; $display("FAIL lu3_state: got %0d want %0d", u_b.r_state, HZ_LU_STALL); end
        step(); set_b(bus(9,1,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), 1,0,0,1,0); #3;
        n_cmp++; if (if_b.stall_o !== S_LU) begin n_err++; $display("FAIL lu3_cyc3: got %b want %b", if_b.stall_o, S_LU); end
        step(); #3;
        n_cmp++; if (if_b.stall_o !== S_NONE) begin n_err++; $display("FAIL lu3_release: got %b want %b", if_b.stall_o, S_NONE); end
        n_cmp++; if (if_b.lu_stall_cnt_o !== 32'd3) begin n_err++; $display("FAIL lu3_cnt: got %0d want 3", if_b.lu_stall_cnt_o); end
        idle_all();
    endtask

    task automatic test_reset_mid_stall();
        step(); set_b(bus(4,4,0,0,MEM_NONE), bus(0,0,4,1,MEM_LW), bus(0,0,0,0,MEM_NONE), 1,1,0,1,0); #3;
        n_cmp++; if (if_b.stall_o !== S_LU) begin n_err++; $display("FAIL rst_mid_cyc1: got %b want %b", if_b.stall_o, S_LU); end
        step(); set_b(bus(4,4,0,0,MEM_NONE), bus(0,0,0,0,MEM_NONE), bus(0,0,4,1,MEM_LW), 1,0,1,1,0); #2;
        n_cmp++; if (if_b.stall_o !== S_LU) begin n_err++; $display("FAIL rst_mid_cyc2: got %b want %b", if_b.stall_o, S_LU); end
        rst = 1'b1;
        #1;
        n_cmp++; if (if_b.stall_o !== S_NONE) begin n_err++; $display("FAIL rst_mid_outputs: got %b want %b", if_b.stall_o, S_NONE); end
        n_cmp++; if (if_b.lu_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_lu_cnt: got %0d want 0", if_b.lu_stall_cnt_o); end
        n_cmp++; if (u_b.r_lu_cnt !== 3'd0) begin n_err++; $display("FAIL rst_mid_lu_remaining: got %0d want 0", u_b.r_lu_cnt); end
        n_cmp++; if (if_a.mem_timeout_o !== 1'b0) begin n_err++; $display("FAIL rst_clears_timeout: got %b want 0", if_a.mem_timeout_o); end
        @(negedge clk);
        rst = 1'b0;
        step(); idle_all(); #3;
        n_cmp++; if (u_b.r_state !== HZ_IDLE) begin n_err++; $display("FAIL rst_after_state: got %0d want %0d", u_b.r_state, HZ_IDLE); end
        n_cmp++; if (if_b.stall_o !== S_NONE) begin n_err++; $display("FAIL rst_after_stall: got %b want %b", if_b.stall_o, S_NONE); end
        n_cmp++; if (if_a.mem_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_after_mem_cnt: got %0d want 0", if_a.mem_stall_cnt_o); end
        n_cmp++; if (if_a.lu_stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_after_lu_cnt: got %0d want 0", if_a.lu_stall_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_wins();
        test_mem_wait();
        test_timeout();
        test_lu_multi();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
